// File: rtl/bp_me_packet_serializer_arb.sv
// rtl/bp_me_packet_serializer_arb.sv - round-robin multi-channel packet-to-flit serializer
module bp_me_packet_serializer_arb #(
    parameter int data_width_p = 536,
    parameter int flit_width_p = 64,
    parameter int els_p        = 4,
    localparam int num_flits_lp = (data_width_p + flit_width_p - 1) / flit_width_p,
    localparam int lg_els_lp    = (els_p > 1) ? $clog2(els_p) : 1,
    localparam int lg_flits_lp  = (num_flits_lp > 1) ? $clog2(num_flits_lp) : 1
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [els_p-1:0]              valid_i,
    input  logic [els_p*data_width_p-1:0] data_i,
    output logic [els_p-1:0]              ready_o,
    output logic                          valid_o,
    output logic [flit_width_p-1:0]       data_o,
    output logic [lg_els_lp-1:0]          chan_o,
    output logic [lg_flits_lp-1:0]        flit_idx_o,
    output logic                          last_o,
    input  logic                          yumi_i
);

    // Buffers are stored zero-extended to a whole number of flits so the
    // final flit reads its padding as zeros without extra masking.
    localparam int pad_width_lp = num_flits_lp * flit_width_p;
    localparam logic [lg_flits_lp-1:0] last_idx_lp = lg_flits_lp'(num_flits_lp - 1);
    localparam logic [lg_els_lp-1:0]   top_chan_lp = lg_els_lp'(els_p - 1);

    typedef enum logic {S_IDLE, S_SEND} state_e;

    logic [pad_width_lp-1:0] r_buf [els_p];
    logic [els_p-1:0]        r_full;
    logic [els_p-1:0]        r_ready;
    state_e                  r_state;
    logic [lg_els_lp-1:0]    r_chan;
    logic [lg_els_lp-1:0]    r_rr;
    logic [lg_flits_lp-1:0]  r_idx;
    logic                    r_valid;
    logic                    r_last;
    logic [flit_width_p-1:0] r_data;

    logic                    w_any;
    logic [lg_els_lp-1:0]    w_grant;
    int                      w_scan;
    logic                    w_done;
    logic [els_p-1:0]        w_clear;
    logic [lg_els_lp-1:0]    w_fetch_chan;
    logic [lg_flits_lp-1:0]  w_fetch_idx;
    logic [pad_width_lp-1:0] w_fetch_buf;
    logic [flit_width_p-1:0] w_fetch_flit;

    // Round-robin pick: first full channel at or after r_rr, wrapping; scanned
    // from the far end so the nearest candidate is written last and wins.
    always_comb begin
        w_any   = 1'b0;
        w_grant = '0;
        w_scan  = 0;
        for (int i = els_p - 1; i >= 0; i--) begin
            w_scan = int'(r_rr) + i;
            if (w_scan >= els_p) begin
                w_scan = w_scan - els_p;
            end
            if (r_full[w_scan[lg_els_lp-1:0]]) begin
                w_any   = 1'b1;
                w_grant = w_scan[lg_els_lp-1:0];
            end
        end
    end

    // Packet completion frees the granted channel's buffer.
    always_comb begin
        w_done = (r_state == S_SEND) && yumi_i && r_last;
        for (int k = 0; k < els_p; k++) begin
            w_clear[k] = w_done && (r_chan == lg_els_lp'(k));
        end
    end

    // Flit to present next: flit 0 of the new grant from IDLE, else the following flit.
    always_comb begin
        w_fetch_chan = (r_state == S_IDLE) ? w_grant : r_chan;
        w_fetch_idx  = (r_state == S_IDLE) ? '0 : r_idx + lg_flits_lp'(1);
        w_fetch_buf  = r_buf[w_fetch_chan];
        w_fetch_flit = w_fetch_buf[w_fetch_idx*flit_width_p +: flit_width_p];
    end

    // Packet storage; only written while the entry is empty, so input changes while full are ignored.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < els_p; k++) begin
            if (valid_i[k] && r_ready[k]) begin
                r_buf[k] <= pad_width_lp'(data_i[k*data_width_p +: data_width_p]);
            end
        end
    end

    // Full/ready flags; ready is its own register and rises the cycle after the last-flit yumi.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_full  <= '0;
            r_ready <= '1;
        end else begin
            for (int k = 0; k < els_p; k++) begin
                if (valid_i[k] && r_ready[k]) begin
                    r_full[k]  <= 1'b1;
                    r_ready[k] <= 1'b0;
                end else if (w_clear[k]) begin
                    r_full[k]  <= 1'b0;
                    r_ready[k] <= 1'b1;
                end
            end
        end
    end

    // Arbitration/streaming FSM with registered link outputs; grant is held until the last flit goes.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_chan  <= '0;
            r_idx   <= '0;
            r_last  <= 1'b0;
            r_rr    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_state <= S_SEND;
                        r_valid <= 1'b1;
                        r_chan  <= w_grant;
                        r_idx   <= '0;
                        r_data  <= w_fetch_flit;
                        r_last  <= (num_flits_lp == 1);
                    end
                end
                S_SEND: begin
                    if (yumi_i) begin
                        if (r_last) begin
                            r_state <= S_IDLE;
                            r_valid <= 1'b0;
                            r_data  <= '0;
                            r_idx   <= '0;
                            r_last  <= 1'b0;
                            r_rr    <= (r_chan == top_chan_lp) ? '0 : r_chan + lg_els_lp'(1);
                        end else begin
                            r_idx  <= w_fetch_idx;
                            r_data <= w_fetch_flit;
                            r_last <= (w_fetch_idx == last_idx_lp);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ready_o    = r_ready;
    assign valid_o    = r_valid;
    assign data_o     = r_data;
    assign chan_o     = r_chan;
    assign flit_idx_o = r_idx;
    assign last_o     = r_last;

    // The link may only consume a flit that is actually being offered.
    a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_i) yumi_i |-> valid_o);

endmodule
